// File: rtl/digit_centering_pkg.sv
// Shared definitions for the digit centering stage.
// Holds the default frame geometry, the centre coordinate helper,
// the coordinate/offset widths and the FSM state type.
package digit_centering_pkg;

    localparam int unsigned IMG_W_DEFAULT = 28;
    localparam int unsigned IMG_H_DEFAULT = 28;

    // Row/column counters, signed translation offsets, and signed source
    // coordinates (wide enough to hold 27 + 14 or 0 - 13 without wrapping).
    localparam int unsigned COORD_W = 5;
    localparam int unsigned OFFS_W  = 6;
    localparam int unsigned SRC_W   = 7;

    // Centre pixel of an n-wide axis, e.g. 13 for 28.
    function automatic int unsigned center_of(input int unsigned n);
        return (n - 1) >> 1;
    endfunction

    localparam int unsigned CENTER_R = center_of(IMG_H_DEFAULT);
    localparam int unsigned CENTER_C = center_of(IMG_W_DEFAULT);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC    = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic signed [OFFS_W-1:0]  offs_t;
    typedef logic signed [SRC_W-1:0]   src_t;

endpackage

// File: rtl/digit_centering_bit_frame_buffer.sv
// One-frame, 1-bit pixel store for the digit centering stage.
// Ports:
//   clk        - clock
//   i_we       - write enable
//   i_wr_row   - write row (0..IMG_H-1)
//   i_wr_col   - write column (0..IMG_W-1)
//   i_wr_data  - pixel to store
//   i_rd_row   - signed source row for the asynchronous read
//   i_rd_col   - signed source column for the asynchronous read
//   o_rd_data  - stored pixel, or 0 when (row,col) lies outside the frame
module bit_frame_buffer
    import digit_centering_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEFAULT,
    parameter int unsigned IMG_H = IMG_H_DEFAULT
)(
    input  logic   clk,
    input  logic   i_we,
    input  coord_t i_wr_row,
    input  coord_t i_wr_col,
    input  logic   i_wr_data,
    input  src_t   i_rd_row,
    input  src_t   i_rd_col,
    output logic   o_rd_data
);

    localparam int unsigned DEPTH = IMG_W * IMG_H;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_in_range;

    assign w_wr_idx = IDX_W'(i_wr_row) * IDX_W'(IMG_W) + IDX_W'(i_wr_col);

    // Sign bit clear means non-negative; the remaining bits are then
    // compared against the frame size as plain unsigned values.
    assign w_rd_in_range = !i_rd_row[SRC_W-1] && !i_rd_col[SRC_W-1]
                        && (i_rd_row[SRC_W-2:0] < (SRC_W-1)'(IMG_H))
                        && (i_rd_col[SRC_W-2:0] < (SRC_W-1)'(IMG_W));

    assign w_rd_idx = IDX_W'(i_rd_row[COORD_W-1:0]) * IDX_W'(IMG_W)
                    + IDX_W'(i_rd_col[COORD_W-1:0]);

    assign o_rd_data = w_rd_in_range ? r_mem[w_rd_idx] : 1'b0;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

endmodule

// File: rtl/digit_centering.sv
// Digit centering stage: buffers one binary frame, tracks the foreground
// bounding box, then re-emits the frame shifted so the box centre lands
// on the frame centre pixel.
// Ports:
//   clk             - clock
//   rst             - synchronous, active-high reset
//   pixel_in        - binary pixel, raster order
//   pixel_valid_in  - pixel_in valid this cycle
//   frame_start     - start/restart frame capture (wins over pixel_valid_in)
//   pixel_out       - centred pixel, raster order
//   pixel_valid_out - pixel_out valid
//   frame_done      - pulse with the last output pixel
//   empty_frame     - last captured frame had no foreground
//   busy            - high while computing/emitting; input is ignored then
module digit_centering
    import digit_centering_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEFAULT,
    parameter int unsigned IMG_H = IMG_H_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic pixel_in,
    input  logic pixel_valid_in,
    input  logic frame_start,
    output logic pixel_out,
    output logic pixel_valid_out,
    output logic frame_done,
    output logic empty_frame,
    output logic busy
);

    localparam coord_t             LAST_ROW = COORD_W'(IMG_H - 1);
    localparam coord_t             LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [OFFS_W-1:0]  CTR_R    = OFFS_W'(center_of(IMG_H));
    localparam logic [OFFS_W-1:0]  CTR_C    = OFFS_W'(center_of(IMG_W));

    state_t r_state;
    coord_t r_row;
    coord_t r_col;
    coord_t r_min_r;
    coord_t r_max_r;
    coord_t r_min_c;
    coord_t r_max_c;
    logic   r_any_fg;
    offs_t  r_dy;
    offs_t  r_dx;

    logic   r_pixel_out;
    logic   r_pixel_valid_out;
    logic   r_frame_done;
    logic   r_empty_frame;
    logic   r_busy;

    logic               w_wr_en;
    logic               w_row_last;
    logic               w_col_last;
    logic [COORD_W:0]   w_sum_r;
    logic [COORD_W:0]   w_sum_c;
    coord_t             w_cr;
    coord_t             w_cc;
    offs_t              w_dy;
    offs_t              w_dx;
    src_t               w_sr;
    src_t               w_sc;
    logic               w_rd_data;

    assign w_wr_en    = (r_state == ST_COLLECT) && pixel_valid_in && !frame_start && !rst;
    assign w_row_last = (r_row == LAST_ROW);
    assign w_col_last = (r_col == LAST_COL);

    // Bounding-box centre and the translation that moves it to the frame centre.
    assign w_sum_r = {1'b0, r_min_r} + {1'b0, r_max_r};
    assign w_sum_c = {1'b0, r_min_c} + {1'b0, r_max_c};
    assign w_cr    = w_sum_r[COORD_W:1];
    assign w_cc    = w_sum_c[COORD_W:1];
    assign w_dy    = CTR_R - {1'b0, w_cr};
    assign w_dx    = CTR_C - {1'b0, w_cc};

    // During EMIT the row/col counters walk the output coordinate; the source
    // pixel is that coordinate minus the offset, sign-extended to 7 bits.
    assign w_sr = {2'b00, r_row} - {{(SRC_W-OFFS_W){r_dy[OFFS_W-1]}}, r_dy};
    assign w_sc = {2'b00, r_col} - {{(SRC_W-OFFS_W){r_dx[OFFS_W-1]}}, r_dx};

    bit_frame_buffer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_buf (
        .clk       (clk),
        .i_we      (w_wr_en),
        .i_wr_row  (r_row),
        .i_wr_col  (r_col),
        .i_wr_data (pixel_in),
        .i_rd_row  (w_sr),
        .i_rd_col  (w_sc),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_COLLECT;
            r_row             <= '0;
            r_col             <= '0;
            r_min_r           <= LAST_ROW;
            r_max_r           <= '0;
            r_min_c           <= LAST_COL;
            r_max_c           <= '0;
            r_any_fg          <= 1'b0;
            r_dy              <= '0;
            r_dx              <= '0;
            r_pixel_out       <= 1'b0;
            r_pixel_valid_out <= 1'b0;
            r_frame_done      <= 1'b0;
            r_empty_frame     <= 1'b0;
            r_busy            <= 1'b0;
        end else if (frame_start) begin
            // Restart capture from any state; empty_frame keeps its last value.
            r_state           <= ST_COLLECT;
            r_row             <= '0;
            r_col             <= '0;
            r_min_r           <= LAST_ROW;
            r_max_r           <= '0;
            r_min_c           <= LAST_COL;
            r_max_c           <= '0;
            r_any_fg          <= 1'b0;
            r_pixel_out       <= 1'b0;
            r_pixel_valid_out <= 1'b0;
            r_frame_done      <= 1'b0;
            r_busy            <= 1'b0;
        end else begin
            r_pixel_out       <= 1'b0;
            r_pixel_valid_out <= 1'b0;
            r_frame_done      <= 1'b0;

            case (r_state)
                ST_COLLECT: begin
                    if (pixel_valid_in) begin
                        if (pixel_in) begin
                            r_any_fg <= 1'b1;
                            if (r_row < r_min_r) r_min_r <= r_row;
                            if (r_row > r_max_r) r_max_r <= r_row;
                            if (r_col < r_min_c) r_min_c <= r_col;
                            if (r_col > r_max_c) r_max_c <= r_col;
                        end
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= ST_CALC;
                                r_busy  <= 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                ST_CALC: begin
                    if (r_any_fg) begin
                        r_dy          <= w_dy;
                        r_dx          <= w_dx;
                        r_empty_frame <= 1'b0;
                    end else begin
                        r_dy          <= '0;
                        r_dx          <= '0;
                        r_empty_frame <= 1'b1;
                    end
                    r_state <= ST_EMIT;
                end

                ST_EMIT: begin
                    r_pixel_out       <= w_rd_data;
                    r_pixel_valid_out <= 1'b1;
                    if (w_col_last) begin
                        r_col <= '0;
                        if (w_row_last) begin
                            r_row        <= '0;
                            r_frame_done <= 1'b1;
                            r_state      <= ST_COLLECT;
                            r_busy       <= 1'b0;
                            r_min_r      <= LAST_ROW;
                            r_max_r      <= '0;
                            r_min_c      <= LAST_COL;
                            r_max_c      <= '0;
                            r_any_fg     <= 1'b0;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

    assign pixel_out       = r_pixel_out;
    assign pixel_valid_out = r_pixel_valid_out;
    assign frame_done      = r_frame_done;
    assign empty_frame     = r_empty_frame;
    assign busy            = r_busy;

endmodule

// File: tb/tb_digit_centering.sv
// Testbench for digit_centering: drives binary frames (with optional input
// gaps, restarts and resets) and compares the emitted frame against a
// reference centering model computed from the captured input frame.
module tb_digit_centering;

    localparam int W   = 28;
    localparam int H   = 28;
    localparam int N   = W * H;
    localparam int CTR = (H - 1) / 2;

    logic clk = 1'b0;
    logic rst;
    logic pixel_in;
    logic pixel_valid_in;
    logic frame_start;
    logic pixel_out;
    logic pixel_valid_out;
    logic frame_done;
    logic empty_frame;
    logic busy;

    int checks   = 0;
    int failures = 0;

    bit   in_frm  [N];
    bit   exp_frm [N];
    bit   exp_empty;
    bit   got     [N];
    int   got_n;
    int   got_lat;
    int   got_done_cnt;
    int   got_done_idx;
    int   got_gap;
    logic got_busy;

    always #5 clk = ~clk;

    digit_centering #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_in        (pixel_in),
        .pixel_valid_in  (pixel_valid_in),
        .frame_start     (frame_start),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .frame_done      (frame_done),
        .empty_frame     (empty_frame),
        .busy            (busy)
    );

    // Reference: bounding box -> centre -> shift by (centre - box centre).
    function automatic void build_expected();
        int minr = H, maxr = -1, minc = W, maxc = -1;
        int dy = 0, dx = 0;
        int sr, sc;
        bit any = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (in_frm[r*W+c]) begin
                    any = 1;
                    if (r < minr) minr = r;
                    if (r > maxr) maxr = r;
                    if (c < minc) minc = c;
                    if (c > maxc) maxc = c;
                end
        if (any) begin
            dy = CTR - (minr + maxr) / 2;
            dx = CTR - (minc + maxc) / 2;
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                sr = r - dy;
                sc = c - dx;
                exp_frm[r*W+c] = (sr >= 0 && sr < H && sc >= 0 && sc < W) ? in_frm[sr*W+sc] : 1'b0;
            end
        exp_empty = !any;
    endfunction

    function automatic void clear_frame();
        for (int i = 0; i < N; i++) in_frm[i] = 1'b0;
    endfunction

    function automatic void gen_blob();
        int r0, c0, hh, ww;
        clear_frame();
        hh = int'($urandom_range(9, 1));
        ww = int'($urandom_range(9, 1));
        r0 = int'($urandom_range(H - hh, 0));
        c0 = int'($urandom_range(W - ww, 0));
        for (int r = r0; r < r0 + hh; r++)
            for (int c = c0; c < c0 + ww; c++)
                in_frm[r*W+c] = 1'($urandom);
        in_frm[r0*W+c0] = 1'b1;
        in_frm[(r0+hh-1)*W+(c0+ww-1)] = 1'b1;
    endfunction

    function automatic int count_diff();
        int n = 0;
        for (int i = 0; i < N; i++) if (got[i] !== exp_frm[i]) n++;
        return n;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < N; i++) if (got[i] !== exp_frm[i]) return i;
        return -1;
    endfunction

    function automatic int ones_in_got();
        int n = 0;
        for (int i = 0; i < N; i++) if (got[i]) n++;
        return n;
    endfunction

    // Drives in_frm[0..npix-1]; each pixel is preceded by 0..max_gap idle cycles.
    task automatic send_frame(input int npix, input int max_gap);
        int g;
        for (int i = 0; i < npix; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                pixel_valid_in = 1'b0;
                pixel_in       = 1'($urandom);
                @(negedge clk);
            end
            pixel_in       = in_frm[i];
            pixel_valid_in = 1'b1;
            @(negedge clk);
        end
        pixel_valid_in = 1'b0;
        pixel_in       = 1'b0;
    endtask

    // Records up to max_pix output pixels within a cycle budget; with junk set,
    // random input traffic is driven while the DUT is busy.
    task automatic capture(input int max_pix, input bit junk);
        int cycles = 0;
        got_n = 0; got_lat = -1; got_done_cnt = 0; got_done_idx = -1; got_gap = 0; got_busy = 1'b0;
        while (got_n < max_pix && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (pixel_valid_out) begin
                if (got_n == 0) begin
                    got_lat  = cycles;
                    got_busy = busy;
                end
                got[got_n] = pixel_out;
                if (frame_done) begin
                    got_done_cnt++;
                    got_done_idx = got_n;
                end
                got_n++;
            end else begin
                if (got_n > 0) got_gap++;
                if (frame_done) got_done_cnt++;
            end
            if (junk && got_n < max_pix) begin
                pixel_valid_in = 1'($urandom);
                pixel_in       = 1'($urandom);
            end else begin
                pixel_valid_in = 1'b0;
                pixel_in       = 1'b0;
            end
        end
        pixel_valid_in = 1'b0;
        pixel_in       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pixel_out, pixel_valid_out, frame_done, empty_frame, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {pixel_out, pixel_valid_out, frame_done, empty_frame, busy});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_corner_00();
        clear_frame();
        in_frm[0] = 1'b1;
        build_expected();
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        if (got_n !== N) begin failures++; $display("FAIL c00_count got=%0d want=%0d", got_n, N); end
        checks++;
        if (got_lat !== 2) begin failures++; $display("FAIL c00_latency got=%0d want=2", got_lat); end
        checks++;
        if (got_busy !== 1'b1) begin failures++; $display("FAIL c00_busy got=%b want=1", got_busy); end
        checks++;
        if (got[377] !== 1'b1 || ones_in_got() !== 1) begin
            failures++;
            $display("FAIL c00_pixel377 got=%b ones=%0d want=1 ones=1", got[377], ones_in_got());
        end
        checks++;
        if (got_done_cnt !== 1 || got_done_idx !== N - 1) begin
            failures++;
            $display("FAIL c00_frame_done got cnt=%0d idx=%0d want cnt=1 idx=%0d", got_done_cnt, got_done_idx, N - 1);
        end
        checks++;
        if (empty_frame !== 1'b0) begin failures++; $display("FAIL c00_empty got=%b want=0", empty_frame); end
        checks++;
        if (got_gap !== 0) begin failures++; $display("FAIL c00_gapless got=%0d want=0", got_gap); end
    endtask

    task automatic test_corner_2727();
        clear_frame();
        in_frm[N-1] = 1'b1;
        build_expected();
        send_frame(N, 0);
        capture(N, 1);
        checks++;
        if (got_n !== N || got[377] !== 1'b1 || ones_in_got() !== 1) begin
            failures++;
            $display("FAIL c2727_pixel377 got n=%0d px=%b ones=%0d want n=%0d px=1 ones=1",
                     got_n, got[377], ones_in_got(), N);
        end
        checks++;
        if (count_diff() !== 0) begin
            failures++;
            $display("FAIL c2727_data got diffs=%0d first=%0d want diffs=0", count_diff(), first_diff());
        end
    endtask

    task automatic test_centred_square();
        clear_frame();
        for (int r = 10; r <= 16; r++)
            for (int c = 10; c <= 16; c++) in_frm[r*W+c] = 1'b1;
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        begin
            int d = 0;
            for (int i = 0; i < N; i++) if (got[i] !== in_frm[i]) d++;
            if (got_n !== N || d !== 0) begin
                failures++;
                $display("FAIL square_identity got n=%0d diffs=%0d want n=%0d diffs=0", got_n, d, N);
            end
        end
    endtask

    task automatic test_empty_then_fg();
        clear_frame();
        build_expected();
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        if (got_n !== N || ones_in_got() !== 0) begin
            failures++;
            $display("FAIL empty_data got n=%0d ones=%0d want n=%0d ones=0", got_n, ones_in_got(), N);
        end
        checks++;
        if (empty_frame !== 1'b1) begin failures++; $display("FAIL empty_flag got=%b want=1", empty_frame); end
        clear_frame();
        in_frm[5*W+20] = 1'b1;
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        if (got[13*W+13] !== 1'b1 || ones_in_got() !== 1) begin
            failures++;
            $display("FAIL fg_after_empty got px=%b ones=%0d want px=1 ones=1", got[13*W+13], ones_in_got());
        end
        checks++;
        if (empty_frame !== 1'b0) begin failures++; $display("FAIL fg_after_empty_flag got=%b want=0", empty_frame); end
    endtask

    task automatic test_abort_emit();
        logic held_empty;
        int   stray;
        gen_blob();
        send_frame(N, 0);
        capture(101, 0);
        checks++;
        if (got_n !== 101) begin failures++; $display("FAIL abort_prefix got=%0d want=101", got_n); end
        held_empty  = empty_frame;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (pixel_valid_out !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_next_cycle got valid=%b done=%b want valid=0 done=0", pixel_valid_out, frame_done);
        end
        stray = 0;
        repeat (800) begin
            @(negedge clk);
            if (pixel_valid_out || frame_done) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL abort_no_output got=%0d want=0", stray); end
        checks++;
        if (empty_frame !== held_empty) begin
            failures++;
            $display("FAIL abort_empty_hold got=%b want=%b", empty_frame, held_empty);
        end
        clear_frame();
        in_frm[2*W+3] = 1'b1;
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        if (got_n !== N || got[13*W+13] !== 1'b1 || ones_in_got() !== 1) begin
            failures++;
            $display("FAIL abort_new_frame got n=%0d px=%b ones=%0d want n=%0d px=1 ones=1",
                     got_n, got[13*W+13], ones_in_got(), N);
        end
        checks++;
        if (got_done_cnt !== 1 || got_done_idx !== N - 1) begin
            failures++;
            $display("FAIL abort_new_done got cnt=%0d idx=%0d want cnt=1 idx=%0d", got_done_cnt, got_done_idx, N - 1);
        end
    endtask

    task automatic test_gaps_and_drop();
        gen_blob();
        send_frame(300, 3);
        frame_start    = 1'b1;
        pixel_valid_in = 1'b1;
        pixel_in       = 1'b1;
        @(negedge clk);
        frame_start    = 1'b0;
        pixel_valid_in = 1'b0;
        pixel_in       = 1'b0;
        gen_blob();
        build_expected();
        send_frame(N, 3);
        capture(N, 1);
        checks++;
        if (got_n !== N || count_diff() !== 0) begin
            failures++;
            $display("FAIL gaps_data got n=%0d diffs=%0d first=%0d want n=%0d diffs=0",
                     got_n, count_diff(), first_diff(), N);
        end
        checks++;
        if (got_lat !== 2 || got_gap !== 0) begin
            failures++;
            $display("FAIL gaps_timing got lat=%0d gaps=%0d want lat=2 gaps=0", got_lat, got_gap);
        end
    endtask

    task automatic test_rst_mid_collect();
        clear_frame();
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        if (empty_frame !== 1'b1) begin failures++; $display("FAIL rst_pre_empty got=%b want=1", empty_frame); end
        gen_blob();
        send_frame(400, 1);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pixel_out, pixel_valid_out, frame_done, empty_frame, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%b want=00000",
                     {pixel_out, pixel_valid_out, frame_done, empty_frame, busy});
        end
        rst = 1'b0;
        @(negedge clk);
        gen_blob();
        build_expected();
        send_frame(N, 0);
        capture(N, 0);
        checks++;
        if (got_n !== N || count_diff() !== 0) begin
            failures++;
            $display("FAIL rst_recapture got n=%0d diffs=%0d first=%0d want n=%0d diffs=0",
                     got_n, count_diff(), first_diff(), N);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            gen_blob();
            build_expected();
            send_frame(N, (k % 2) * 2);
            capture(N, 1);
            checks++;
            if (got_n !== N || count_diff() !== 0) begin
                failures++;
                $display("FAIL b2b_data[%0d] got n=%0d diffs=%0d first=%0d want n=%0d diffs=0",
                         k, got_n, count_diff(), first_diff(), N);
            end
            checks++;
            if (got_done_cnt !== 1 || got_done_idx !== N - 1 || empty_frame !== exp_empty) begin
                failures++;
                $display("FAIL b2b_flags[%0d] got cnt=%0d idx=%0d empty=%b want cnt=1 idx=%0d empty=%b",
                         k, got_done_cnt, got_done_idx, empty_frame, N - 1, exp_empty);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        pixel_in       = 1'b0;
        pixel_valid_in = 1'b0;
        frame_start    = 1'b0;
        @(negedge clk);
        test_reset();
        test_corner_00();
        test_corner_2727();
        test_centred_square();
        test_empty_then_fg();
        test_abort_emit();
        test_gaps_and_drop();
        test_rst_mid_collect();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
